// File: rtl/health_tracker.sv
// health_tracker: per-round fighter health, hit invulnerability, KO detection and round sequencing
module health_tracker #(
   parameter int FULL_HEALTH    = 31,
   parameter int INVULN_CYCLES  = 25_000_000,
   parameter int KO_HOLD_CYCLES = 200_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       round_start,
   input  logic       hit_l_valid,
   input  logic [4:0] hit_l_dmg,
   input  logic       hit_r_valid,
   input  logic [4:0] hit_r_dmg,
   output logic [4:0] curr_health_l,
   output logic [4:0] curr_health_r,
   output logic       invuln_l,
   output logic       invuln_r,
   output logic       hit_ack_l,
   output logic       hit_ack_r,
   output logic       round_over,
   output logic [1:0] winner
);
   localparam int MAX_T = INVULN_CYCLES > KO_HOLD_CYCLES ? INVULN_CYCLES : KO_HOLD_CYCLES;
   localparam int TW = $clog2(MAX_T + 1);
   localparam logic [4:0] FULL = 5'(FULL_HEALTH);
   localparam logic [TW-1:0] INV_LOAD = TW'(INVULN_CYCLES);
   localparam logic [TW-1:0] KO_LOAD = TW'(KO_HOLD_CYCLES - 1);
   localparam logic [TW-1:0] ONE = TW'(1);

   typedef enum logic [1:0] {IDLE, FIGHT, KO} state_t;

   state_t state, state_n;
   logic [TW-1:0] inv_l_cnt, inv_r_cnt, ko_cnt, inv_l_n, inv_r_n, ko_n;
   logic [4:0] health_l_n, health_r_n, hit_l_hp, hit_r_hp;
   logic [5:0] diff_l, diff_r;
   logic ack_l_n, ack_r_n, take_l, take_r;
   logic [1:0] winner_n;

   // The window is live while its countdown is nonzero; the count is cleared on KO entry so KO forces it low.
   assign invuln_l = inv_l_cnt != '0;
   assign invuln_r = inv_r_cnt != '0;
   assign round_over = state == KO;

   // Subtraction is one bit wider than health so an underflow shows up as a set sign bit and saturates to 0.
   assign diff_l = {1'b0, curr_health_l} - {1'b0, hit_l_dmg};
   assign diff_r = {1'b0, curr_health_r} - {1'b0, hit_r_dmg};
   assign hit_l_hp = diff_l[5] ? 5'd0 : diff_l[4:0];
   assign hit_r_hp = diff_r[5] ? 5'd0 : diff_r[4:0];
   assign take_l = state == FIGHT && hit_l_valid && !invuln_l && hit_l_dmg != 5'd0;
   assign take_r = state == FIGHT && hit_r_valid && !invuln_r && hit_r_dmg != 5'd0;

   // Next-state and next-datapath values; round_start outranks any hit arriving in the same cycle.
   always_comb begin
      state_n = state;
      health_l_n = curr_health_l;
      health_r_n = curr_health_r;
      inv_l_n = invuln_l ? inv_l_cnt - ONE : '0;
      inv_r_n = invuln_r ? inv_r_cnt - ONE : '0;
      ko_n = ko_cnt;
      ack_l_n = 1'b0;
      ack_r_n = 1'b0;
      winner_n = winner;
      case (state)
         IDLE: begin
            if (round_start) begin
               state_n = FIGHT;
               health_l_n = FULL;
               health_r_n = FULL;
               inv_l_n = '0;
               inv_r_n = '0;
            end
         end
         FIGHT: begin
            if (round_start) begin
               health_l_n = FULL;
               health_r_n = FULL;
               inv_l_n = '0;
               inv_r_n = '0;
            end else begin
               if (take_l) begin
                  health_l_n = hit_l_hp;
                  ack_l_n = 1'b1;
                  inv_l_n = INV_LOAD;
               end
               if (take_r) begin
                  health_r_n = hit_r_hp;
                  ack_r_n = 1'b1;
                  inv_r_n = INV_LOAD;
               end
               if (health_l_n == 5'd0 || health_r_n == 5'd0) begin
                  state_n = KO;
                  inv_l_n = '0;
                  inv_r_n = '0;
                  ko_n = KO_LOAD;
                  winner_n = {health_l_n == 5'd0, health_r_n == 5'd0};
               end
            end
         end
         KO: begin
            if (ko_cnt == '0) begin
               state_n = IDLE;
               winner_n = 2'b00;
            end else begin
               ko_n = ko_cnt - ONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Register the FSM and datapath; reset reloads full health and clears every flag and timer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         curr_health_l <= FULL;
         curr_health_r <= FULL;
         inv_l_cnt <= '0;
         inv_r_cnt <= '0;
         ko_cnt <= '0;
         hit_ack_l <= 1'b0;
         hit_ack_r <= 1'b0;
         winner <= 2'b00;
      end else begin
         state <= state_n;
         curr_health_l <= health_l_n;
         curr_health_r <= health_r_n;
         inv_l_cnt <= inv_l_n;
         inv_r_cnt <= inv_r_n;
         ko_cnt <= ko_n;
         hit_ack_l <= ack_l_n;
         hit_ack_r <= ack_r_n;
         winner <= winner_n;
      end
   end
endmodule

// File: tb/tb_health_tracker.sv
// tb_health_tracker: directed scenarios plus random traffic against a cycle-stamp reference model
module tb_health_tracker;
   localparam int FH = 31;
   localparam int INV = 4;
   localparam int KOH = 8;

   logic clk = 0;
   logic rst_n = 0;
   logic round_start = 0;
   logic hit_l_valid = 0;
   logic hit_r_valid = 0;
   logic [4:0] hit_l_dmg = 0;
   logic [4:0] hit_r_dmg = 0;
   logic [4:0] curr_health_l, curr_health_r;
   logic invuln_l, invuln_r, hit_ack_l, hit_ack_r, round_over;
   logic [1:0] winner;
   logic [16:0] obs;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase 0 idle, 1 fight, 2 KO; invulnerability and KO hold derived from edge stamps.
   int cyc = 0;
   int m_phase = 0;
   int m_hl = FH;
   int m_hr = FH;
   int last_l = -1000;
   int last_r = -1000;
   int ko_start = 0;
   int m_win = 0;
   bit m_ack_l = 0;
   bit m_ack_r = 0;

   always #5 clk = ~clk;

   health_tracker #(.FULL_HEALTH(FH), .INVULN_CYCLES(INV), .KO_HOLD_CYCLES(KOH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .round_start(round_start),
      .hit_l_valid(hit_l_valid),
      .hit_l_dmg(hit_l_dmg),
      .hit_r_valid(hit_r_valid),
      .hit_r_dmg(hit_r_dmg),
      .curr_health_l(curr_health_l),
      .curr_health_r(curr_health_r),
      .invuln_l(invuln_l),
      .invuln_r(invuln_r),
      .hit_ack_l(hit_ack_l),
      .hit_ack_r(hit_ack_r),
      .round_over(round_over),
      .winner(winner)
   );

   assign obs = {curr_health_l, curr_health_r, invuln_l, invuln_r, hit_ack_l, hit_ack_r, round_over, winner};

   function automatic logic [16:0] expv();
      logic il, ir;
      il = m_phase == 1 && (cyc - last_l) < INV;
      ir = m_phase == 1 && (cyc - last_r) < INV;
      return {5'(m_hl), 5'(m_hr), il, ir, m_ack_l, m_ack_r, m_phase == 2, 2'(m_win)};
   endfunction

   task automatic drive(input bit rs, input bit lv, input int ld, input bit rv, input int rd);
      round_start = rs;
      hit_l_valid = lv;
      hit_l_dmg = 5'(ld);
      hit_r_valid = rv;
      hit_r_dmg = 5'(rd);
   endtask

   // One clock edge: advance the model with the inputs present at the edge, then settle before sampling.
   task automatic step();
      bit il, ir;
      @(posedge clk);
      cyc++;
      il = (cyc - 1 - last_l) < INV;
      ir = (cyc - 1 - last_r) < INV;
      m_ack_l = 0;
      m_ack_r = 0;
      if (!rst_n) begin
         m_phase = 0; m_hl = FH; m_hr = FH; last_l = -1000; last_r = -1000; m_win = 0;
      end else if (m_phase == 0) begin
         if (round_start) begin
            m_phase = 1; m_hl = FH; m_hr = FH; last_l = -1000; last_r = -1000;
         end
      end else if (m_phase == 1) begin
         if (round_start) begin
            m_hl = FH; m_hr = FH; last_l = -1000; last_r = -1000;
         end else begin
            if (hit_l_valid && !il && hit_l_dmg != 0) begin
               m_hl = m_hl > int'(hit_l_dmg) ? m_hl - int'(hit_l_dmg) : 0;
               m_ack_l = 1; last_l = cyc;
            end
            if (hit_r_valid && !ir && hit_r_dmg != 0) begin
               m_hr = m_hr > int'(hit_r_dmg) ? m_hr - int'(hit_r_dmg) : 0;
               m_ack_r = 1; last_r = cyc;
            end
            if (m_hl == 0 || m_hr == 0) begin
               m_phase = 2; ko_start = cyc;
               m_win = (m_hl == 0 ? 2 : 0) + (m_hr == 0 ? 1 : 0);
            end
         end
      end else if (cyc - ko_start == KOH) begin
         m_phase = 0; m_win = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      drive(0, 1, 7, 1, 7);
      step();
      step();
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL reset_model: dut=%h model=%h", obs, expv()); end
      vectors++;
      if ({curr_health_l, curr_health_r, round_over, winner, hit_ack_l, invuln_r} !== {5'd31, 5'd31, 1'b0, 2'b00, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL reset_values: hl=%0d hr=%0d ro=%b win=%b", curr_health_l, curr_health_r, round_over, winner);
      end
      rst_n = 1;
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_first_hit();
      int n;
      drive(1, 0, 0, 0, 0); step();
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL start: dut=%h model=%h", obs, expv()); end
      drive(0, 0, 0, 1, 5); step();
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL hit5_model: dut=%h model=%h", obs, expv()); end
      vectors++;
      if (curr_health_r !== 5'd26 || hit_ack_r !== 1'b1) begin miscompares++; $display("FAIL hit5: hr=%0d ack=%b need 26/1", curr_health_r, hit_ack_r); end
      n = int'(invuln_r);
      drive(0, 0, 0, 1, 3); step();
      n += int'(invuln_r);
      vectors++;
      if (curr_health_r !== 5'd26 || hit_ack_r !== 1'b0) begin miscompares++; $display("FAIL invuln_drop: hr=%0d ack=%b need 26/0", curr_health_r, hit_ack_r); end
      drive(0, 0, 0, 0, 0);
      repeat (3) begin
         step();
         n += int'(invuln_r);
         vectors++;
         if (obs !== expv()) begin miscompares++; $display("FAIL invuln_win: dut=%h model=%h", obs, expv()); end
      end
      vectors++;
      if (n !== 4 || invuln_r !== 1'b0) begin miscompares++; $display("FAIL invuln_len: got %0d cycles need 4", n); end
      drive(0, 0, 0, 1, 3); step();
      vectors++;
      if (curr_health_r !== 5'd23 || hit_ack_r !== 1'b1) begin miscompares++; $display("FAIL hit3: hr=%0d ack=%b need 23/1", curr_health_r, hit_ack_r); end
      drive(0, 0, 0, 0, 0); step();
      vectors++;
      if (hit_ack_r !== 1'b0 || obs !== expv()) begin miscompares++; $display("FAIL ack_pulse: dut=%h model=%h", obs, expv()); end
   endtask

   task automatic test_ko_left();
      int n;
      drive(1, 0, 0, 0, 0); step();
      drive(0, 1, 27, 0, 0); step();
      drive(0, 0, 0, 0, 0);
      repeat (4) step();
      vectors++;
      if (curr_health_l !== 5'd4 || invuln_l !== 1'b0) begin miscompares++; $display("FAIL ko_setup: hl=%0d inv=%b need 4/0", curr_health_l, invuln_l); end
      drive(0, 1, 10, 0, 0); step();
      vectors++;
      if (curr_health_l !== 5'd0 || round_over !== 1'b1 || winner !== 2'b10) begin
         miscompares++; $display("FAIL ko_left: hl=%0d ro=%b win=%b need 0/1/10", curr_health_l, round_over, winner);
      end
      n = int'(round_over);
      repeat (KOH) begin
         drive(1, 1, 3, 1, 3);
         step();
         n += int'(round_over);
         vectors++;
         if (obs !== expv()) begin miscompares++; $display("FAIL ko_hold: dut=%h model=%h", obs, expv()); end
      end
      vectors++;
      if (n !== KOH || round_over !== 1'b0 || curr_health_l !== 5'd0 || winner !== 2'b00) begin
         miscompares++; $display("FAIL ko_exit: ro_cycles=%0d ro=%b hl=%0d need %0d/0/0", n, round_over, curr_health_l, KOH);
      end
      drive(0, 1, 5, 1, 5); step();
      vectors++;
      if (hit_ack_l !== 1'b0 || hit_ack_r !== 1'b0 || curr_health_r !== 5'd31 || obs !== expv()) begin
         miscompares++; $display("FAIL idle_hit: dut=%h model=%h", obs, expv());
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_double_ko();
      drive(1, 0, 0, 0, 0); step();
      drive(0, 1, 29, 1, 29); step();
      drive(0, 0, 0, 0, 0);
      repeat (4) step();
      drive(0, 1, 2, 1, 2); step();
      vectors++;
      if ({curr_health_l, curr_health_r, winner, round_over} !== {5'd0, 5'd0, 2'b11, 1'b1}) begin
         miscompares++; $display("FAIL double_ko: hl=%0d hr=%0d win=%b need 0/0/11", curr_health_l, curr_health_r, winner);
      end
      drive(0, 0, 0, 0, 0);
      repeat (KOH) step();
      vectors++;
      if (obs !== expv() || round_over !== 1'b0) begin miscompares++; $display("FAIL double_exit: dut=%h model=%h", obs, expv()); end
      drive(1, 0, 0, 0, 0); step();
      vectors++;
      if (curr_health_l !== 5'd31 || curr_health_r !== 5'd31) begin miscompares++; $display("FAIL restart: hl=%0d hr=%0d need 31/31", curr_health_l, curr_health_r); end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_start_priority();
      drive(0, 1, 6, 0, 0); step();
      drive(1, 1, 9, 1, 9); step();
      vectors++;
      if ({curr_health_l, curr_health_r, hit_ack_l, hit_ack_r, invuln_l, invuln_r} !== {5'd31, 5'd31, 4'b0000}) begin
         miscompares++; $display("FAIL start_priority: dut=%h model=%h", obs, expv());
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_ko();
      drive(0, 1, 31, 0, 0); step();
      vectors++;
      if (round_over !== 1'b1 || winner !== 2'b10) begin miscompares++; $display("FAIL pre_rst_ko: ro=%b win=%b need 1/10", round_over, winner); end
      drive(0, 0, 0, 0, 0);
      repeat (2) step();
      rst_n = 0; step(); rst_n = 1;
      vectors++;
      if (obs !== {5'd31, 5'd31, 7'd0}) begin miscompares++; $display("FAIL rst_mid_ko: dut=%h need %h", obs, {5'd31, 5'd31, 7'd0}); end
      vectors++;
      if (obs !== expv()) begin miscompares++; $display("FAIL rst_mid_ko_model: dut=%h model=%h", obs, expv()); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst_n = $urandom_range(0, 199) != 0;
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 12),
               $urandom_range(0, 2) == 0, $urandom_range(0, 12));
         step();
         vectors++;
         if (obs !== expv()) begin miscompares++; $display("FAIL random cyc %0d: dut=%h model=%h", cyc, obs, expv()); end
      end
      rst_n = 1;
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_ko_left();
      test_double_ko();
      test_start_priority();
      test_reset_mid_ko();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
